boot_rom_port_arb: RTL and testbench
====================================

# boot_rom_port_arb

Two-port front-end that sits directly upstream of the boot ROM and drives its chip-select/address pins. It arbitrates between the core instruction-fetch port and a data port (boot code reads constants), both using the req/gnt/rvalid memory protocol. It converts granted reads into ROM accesses and returns read data one cycle after grant. Writes and out-of-range word indices are answered with an error response and never reach the ROM.

## Interface
- ROM_WORDS, 548, number of populated ROM words; word index >= ROM_WORDS is out of range
- ROM_AW, 10, ROM word-address width
- CLK  in  1  single clock, all state on rising edge
- RSTN  in  1  asynchronous, active-low reset
- instr_req_i  in  1  instruction read request
- instr_addr_i  in  32  byte address; word index = addr[ROM_AW+1:2]
- instr_gnt_o  out  1  request accepted this cycle
- instr_rvalid_o  out  1  response valid
- instr_rdata_o  out  32  response data
- instr_err_o  out  1  response is an error
- data_req_i, data_addr_i[31:0], data_we_i, data_gnt_o, data_rvalid_o, data_rdata_o[31:0], data_err_o: same meaning for the data port; data_we_i=1 marks a write
- rom_csn_o  out  1  ROM chip select, active low
- rom_a_o  out  ROM_AW  ROM word address
- rom_q_i  in  32  ROM data, valid the cycle after rom_csn_o low, held stable while rom_csn_o high

## Operation
- Grant is combinational: at most one of instr_gnt_o/data_gnt_o per cycle, only when the matching req is high.
- Arbitration: single requester wins. Both requesting: round-robin on a last-winner register; reset value = data, so instr wins first conflict. Last-winner updates only on a grant.
- Granted read, in range: rom_csn_o=0, rom_a_o=word index, same cycle. Otherwise rom_csn_o=1 and rom_a_o holds its previous value.
- Granted write or out-of-range read: no ROM access; response err=1, rdata=0.
- Response register captures {port, kind ∈ ROM/ERR/HIT} at grant; next cycle asserts rvalid on that port only. Kind ROM: rdata=rom_q_i, err=0. Requesters always accept rvalid (no response backpressure).
- Address bits [1:0] and above ROM_AW+1 are ignored (no alignment or range error from them).

## Timing
- Reset values: gnt 0 (combinational, reqs low), all rvalid 0, rdata 0, err 0, rom_csn_o 1, rom_a_o 0, last-winner = data, response register empty.
- Latency: grant cycle N -> rvalid cycle N+1, fixed for all kinds.
- Throughput: one grant per cycle; back-to-back grants to same or alternating ports allowed, responses strictly in grant order.
- Conflicting requests every cycle alternate instr, data, instr, ...
- Reset asserted mid-operation: pending response dropped, rvalid 0 from reset assertion; no response issued after release for pre-reset grants.
- rdata/err are 0 whenever the corresponding rvalid is 0.

## Configuration
- BOOT_ROM_LAST_HIT_EN defined: one-entry buffer {valid, index, data}. A granted in-range read whose index equals the buffered index with valid=1 is served as kind HIT: rom_csn_o stays 1, rdata=buffered data next cycle. Buffer loads index at grant of a ROM-kind read and data from rom_q_i in the response cycle; valid set then. Valid 0 at reset. A HIT granted in the same cycle a ROM response is returning to that index must use rom_q_i (bypass).
- Not defined: no buffer, every in-range read accesses the ROM; kind HIT never occurs.

## Structure
- Package boot_rom_pkg: ROM_WORDS default constant, enum rsp_kind_e {RSP_ROM, RSP_ERR, RSP_HIT}, enum port_e {PORT_INSTR, PORT_DATA}, response-register struct.
- Sub-module boot_rom_rr_arb: 2-input round-robin arbiter (req[1:0] -> gnt[1:0], last-winner state, advances on grant).

## Test plan
- Reset, then instr read 0x0000_0080 -> instr_gnt_o same cycle, rom_csn_o=0, rom_a_o=0x020; next cycle instr_rvalid_o=1, rdata=ROM word 32, err=0.
- Both ports request continuously, addresses 0x0 and 0x4 -> grants alternate instr, data, instr; each rvalid on correct port with matching word one cycle later.
- data_we_i=1 to 0x10 -> data_gnt_o=1, rom_csn_o=1; next cycle data_rvalid_o=1, err=1, rdata=0.
- Instr read byte address 0x890 (index 548 >= ROM_WORDS) -> no ROM access; rvalid next cycle with err=1, rdata=0.
- Grant at cycle N, RSTN low at N+0.5 -> no rvalid at N+1 or after release; outputs at reset values.
- With BOOT_ROM_LAST_HIT_EN: two consecutive reads of 0x100 -> first drives rom_csn_o=0, second keeps rom_csn_o=1; both return same data.

Source files
------------

// File: rtl/boot_rom_pkg.sv
// Shared types and defaults for the boot ROM port arbiter.
package boot_rom_pkg;

  localparam int unsigned ROM_WORDS_DEF = 548;
  localparam int unsigned ROM_AW_DEF    = 10;
  localparam int unsigned DATA_W        = 32;

  typedef enum logic [1:0] {
    RSP_ROM = 2'd0,
    RSP_ERR = 2'd1,
    RSP_HIT = 2'd2
  } rsp_kind_e;

  typedef enum logic {
    PORT_INSTR = 1'b0,
    PORT_DATA  = 1'b1
  } port_e;

  // One pending response: issued the cycle after the grant that created it
  typedef struct packed {
    logic      valid;
    port_e     port;
    rsp_kind_e kind;
  } rsp_reg_t;

endpackage

// File: rtl/boot_rom_rr_arb.sv
// Two-input round-robin arbiter; bit 0 = instr, bit 1 = data. Last winner starts as data.
module boot_rom_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic r_last_data;

  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = r_last_data ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_data <= 1'b1;
    end else if (|o_gnt) begin
      r_last_data <= o_gnt[1];
    end
  end

endmodule

// File: rtl/boot_rom_port_arb.sv
// Instr/data front-end for the boot ROM: grants one read per cycle, answers next cycle.
// Optional last-hit buffer enabled by defining BOOT_ROM_LAST_HIT_EN.
module boot_rom_port_arb
  import boot_rom_pkg::*;
#(
  parameter int unsigned ROM_WORDS = ROM_WORDS_DEF,
  parameter int unsigned ROM_AW    = ROM_AW_DEF
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              instr_req_i,
  input  logic [31:0]       instr_addr_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  output logic [31:0]       instr_rdata_o,
  output logic              instr_err_o,
  input  logic              data_req_i,
  input  logic [31:0]       data_addr_i,
  input  logic              data_we_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  output logic [31:0]       data_rdata_o,
  output logic              data_err_o,
  output logic              rom_csn_o,
  output logic [ROM_AW-1:0] rom_a_o,
  input  logic [31:0]       rom_q_i
);

  logic [1:0]        w_gnt;
  logic [ROM_AW-1:0] w_i_idx;
  logic [ROM_AW-1:0] w_d_idx;
  logic [ROM_AW-1:0] w_idx;
  logic              w_we;
  logic              w_in_range;
  logic              w_rd_ok;
  logic              w_hit;
  logic              w_rom_acc;
  rsp_kind_e         w_kind;
  logic [31:0]       w_rsp_data;
  logic              w_unused_addr;

  rsp_reg_t          r_rsp;
  logic [ROM_AW-1:0] r_rom_a;

  boot_rom_rr_arb u_arb (
    .clk   (CLK),
    .rst_n (RSTN),
    .i_req ({data_req_i, instr_req_i}),
    .o_gnt (w_gnt)
  );

  assign instr_gnt_o = w_gnt[0];
  assign data_gnt_o  = w_gnt[1];

  // Byte offset and bits above the ROM window are ignored by design
  assign w_i_idx       = instr_addr_i[ROM_AW+1:2];
  assign w_d_idx       = data_addr_i[ROM_AW+1:2];
  assign w_unused_addr = ^{instr_addr_i[31:ROM_AW+2], instr_addr_i[1:0],
                           data_addr_i[31:ROM_AW+2], data_addr_i[1:0]};

  assign w_idx      = w_gnt[1] ? w_d_idx : w_i_idx;
  assign w_we       = w_gnt[1] & data_we_i;
  assign w_in_range = 32'(w_idx) < ROM_WORDS;
  assign w_rd_ok    = (|w_gnt) & ~w_we & w_in_range;
  assign w_rom_acc  = w_rd_ok & ~w_hit;

`ifdef BOOT_ROM_LAST_HIT_EN
  logic              w_rom_rsp;
  logic              r_buf_vld;
  logic [ROM_AW-1:0] r_buf_idx;
  logic [31:0]       r_buf_data;

  // A ROM response in flight counts as valid so back-to-back repeats bypass the ROM
  assign w_rom_rsp = r_rsp.valid & (r_rsp.kind == RSP_ROM);
  assign w_hit     = w_rd_ok & (w_idx == r_buf_idx) & (r_buf_vld | w_rom_rsp);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_buf_vld  <= 1'b0;
      r_buf_idx  <= '0;
      r_buf_data <= '0;
    end else begin
      if (w_rom_acc) begin
        r_buf_vld <= 1'b0;
        r_buf_idx <= w_idx;
      end else if (w_rom_rsp) begin
        r_buf_vld <= 1'b1;
      end
      if (w_rom_rsp) begin
        r_buf_data <= rom_q_i;
      end
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  always_comb begin
    w_kind = RSP_ERR;
    if (w_hit) begin
      w_kind = RSP_HIT;
    end else if (w_rom_acc) begin
      w_kind = RSP_ROM;
    end
  end

  assign rom_csn_o = ~w_rom_acc;
  assign rom_a_o   = w_rom_acc ? w_idx : r_rom_a;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_rsp   <= '0;
      r_rom_a <= '0;
    end else begin
      r_rsp.valid <= |w_gnt;
      r_rsp.port  <= port_e'(w_gnt[1]);
      r_rsp.kind  <= w_kind;
      if (w_rom_acc) begin
        r_rom_a <= w_idx;
      end
    end
  end

  always_comb begin
    w_rsp_data = '0;
    case (r_rsp.kind)
      RSP_ROM: w_rsp_data = rom_q_i;
`ifdef BOOT_ROM_LAST_HIT_EN
      RSP_HIT: w_rsp_data = r_buf_data;
`endif
      default: w_rsp_data = '0;
    endcase
  end

  // Response fields are forced to zero whenever rvalid is low
  assign instr_rvalid_o = r_rsp.valid & (r_rsp.port == PORT_INSTR);
  assign data_rvalid_o  = r_rsp.valid & (r_rsp.port == PORT_DATA);
  assign instr_err_o    = instr_rvalid_o & (r_rsp.kind == RSP_ERR);
  assign data_err_o     = data_rvalid_o & (r_rsp.kind == RSP_ERR);
  assign instr_rdata_o  = instr_rvalid_o ? w_rsp_data : 32'h0;
  assign data_rdata_o   = data_rvalid_o ? w_rsp_data : 32'h0;

endmodule

// File: tb/tb_boot_rom_port_arb.sv
// Self-checking bench for boot_rom_port_arb: vector table plus reset and last-hit sequences.
module tb_boot_rom_port_arb;

  logic        CLK;
  logic        RSTN;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;
  logic        data_req_i;
  logic [31:0] data_addr_i;
  logic        data_we_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;
  logic        rom_csn_o;
  logic [9:0]  rom_a_o;
  logic [31:0] rom_q_i;

  boot_rom_port_arb dut (
    .CLK            (CLK),
    .RSTN           (RSTN),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .instr_err_o    (instr_err_o),
    .data_req_i     (data_req_i),
    .data_addr_i    (data_addr_i),
    .data_we_i      (data_we_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .data_err_o     (data_err_o),
    .rom_csn_o      (rom_csn_o),
    .rom_a_o        (rom_a_o),
    .rom_q_i        (rom_q_i)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] rom_fn(input logic [9:0] i);
    return (32'hB007_0000 | 32'(i)) ^ (32'(i) << 20);
  endfunction

  // Behavioural ROM: data appears the cycle after a select, held otherwise
  initial rom_q_i = 32'h0;
  always @(posedge CLK) begin
    if (!rom_csn_o) rom_q_i <= rom_fn(rom_a_o);
  end

  typedef struct {
    logic        port;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic [31:0] da;
    logic        dw;
    logic [1:0]  eg;
    logic        ecsn;
    logic        eerr;
  } vec_t;

  rsp_t        q[$];
  vec_t        tbl[16];
  logic [9:0]  m_a;
  int          n_pass;
  int          n_tot;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk_rsp(input string nm);
    rsp_t e;
    logic iv, dv;
    iv = 1'b0;
    dv = 1'b0;
    e  = '{1'b0, 1'b0, 32'h0};
    if (q.size() > 0) begin
      e  = q.pop_front();
      iv = !e.port;
      dv = e.port;
    end
    chk({nm, ".i_rvalid"}, 32'(instr_rvalid_o), 32'(iv));
    chk({nm, ".i_rdata"},  instr_rdata_o, iv ? e.data : 32'h0);
    chk({nm, ".i_err"},    32'(instr_err_o), 32'(iv & e.err));
    chk({nm, ".d_rvalid"}, 32'(data_rvalid_o), 32'(dv));
    chk({nm, ".d_rdata"},  data_rdata_o, dv ? e.data : 32'h0);
    chk({nm, ".d_err"},    32'(data_err_o), 32'(dv & e.err));
  endtask

  // One clock: drive after the edge, check at the falling edge, queue the expected response
  task automatic step(input logic ir, input logic [31:0] ia, input logic dr,
                      input logic [31:0] da, input logic dw, input logic [1:0] eg,
                      input logic ecsn, input logic eerr, input string nm);
    logic [9:0] idx;
    rsp_t       r;
    @(posedge CLK);
    #1;
    instr_req_i  = ir;
    instr_addr_i = ia;
    data_req_i   = dr;
    data_addr_i  = da;
    data_we_i    = dw;
    @(negedge CLK);
    chk_rsp(nm);
    chk({nm, ".gnt"}, 32'({data_gnt_o, instr_gnt_o}), 32'(eg));
    chk({nm, ".csn"}, 32'(rom_csn_o), 32'(ecsn));
    idx = eg[1] ? da[11:2] : ia[11:2];
    if (!ecsn) m_a = idx;
    chk({nm, ".rom_a"}, 32'(rom_a_o), 32'(m_a));
    if (eg != 2'b00) begin
      r.port = eg[1];
      r.err  = eerr;
      r.data = eerr ? 32'h0 : rom_fn(idx);
      q.push_back(r);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, ".gnt"},   32'({data_gnt_o, instr_gnt_o}), 32'h0);
    chk({nm, ".rv"},    32'({data_rvalid_o, instr_rvalid_o}), 32'h0);
    chk({nm, ".rdata"}, instr_rdata_o | data_rdata_o, 32'h0);
    chk({nm, ".err"},   32'({data_err_o, instr_err_o}), 32'h0);
    chk({nm, ".csn"},   32'(rom_csn_o), 32'h1);
    chk({nm, ".rom_a"}, 32'(rom_a_o), 32'h0);
  endtask

  task automatic do_reset(input string nm);
    RSTN         = 1'b0;
    instr_req_i  = 1'b0;
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    instr_addr_i = 32'h0;
    data_addr_i  = 32'h0;
    #1;
    q.delete();
    m_a = 10'h0;
    chk_reset_vals(nm);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk_reset_vals({nm, ".held"});
    RSTN = 1'b1;
  endtask

  initial begin
    n_pass = 0;
    n_tot  = 0;
    m_a    = 10'h0;

    //            ir    ia             dr    da             dw    eg     csn   err
    tbl[0]  = '{1'b1, 32'h0000_0080, 1'b0, 32'h0,         1'b0, 2'b01, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 2'b00, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 32'h0,         1'b1, 32'h0000_0010, 1'b1, 2'b10, 1'b1, 1'b1};
    tbl[3]  = '{1'b1, 32'h0000_0890, 1'b0, 32'h0,         1'b0, 2'b01, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, 32'h0000_0000, 1'b1, 32'h0000_0004, 1'b0, 2'b10, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 32'h0000_0000, 1'b1, 32'h0000_0004, 1'b0, 2'b01, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 32'h0000_0000, 1'b1, 32'h0000_0004, 1'b0, 2'b10, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 32'h0,         1'b1, 32'h1FFF_F88C, 1'b0, 2'b10, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 32'hFFFF_F003, 1'b0, 32'h0,         1'b0, 2'b01, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 32'h0,         1'b1, 32'h0000_0890, 1'b1, 2'b10, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 32'h0000_0C00, 1'b0, 32'h0,         1'b0, 2'b01, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 32'h0,         1'b1, 32'h0000_0010, 1'b0, 2'b10, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 2'b00, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 32'h0000_0020, 1'b1, 32'h0000_0000, 1'b1, 2'b01, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 32'h0000_0020, 1'b1, 32'h0000_0000, 1'b1, 2'b10, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 2'b00, 1'b1, 1'b0};

    do_reset("reset");
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].ir, tbl[i].ia, tbl[i].dr, tbl[i].da, tbl[i].dw,
           tbl[i].eg, tbl[i].ecsn, tbl[i].eerr, $sformatf("vec%0d", i));
    end

    // Repeated reads of one word: the repeats are served from the last-hit buffer when enabled
    do_reset("reset_hit");
    step(1'b1, 32'h0000_0100, 1'b0, 32'h0, 1'b0, 2'b01, 1'b0, 1'b0, "hit0");
`ifdef BOOT_ROM_LAST_HIT_EN
    step(1'b1, 32'h0000_0100, 1'b0, 32'h0, 1'b0, 2'b01, 1'b1, 1'b0, "hit1");
    step(1'b0, 32'h0, 1'b1, 32'h0000_0100, 1'b0, 2'b10, 1'b1, 1'b0, "hit2");
`else
    step(1'b1, 32'h0000_0100, 1'b0, 32'h0, 1'b0, 2'b01, 1'b0, 1'b0, "hit1");
    step(1'b0, 32'h0, 1'b1, 32'h0000_0100, 1'b0, 2'b10, 1'b0, 1'b0, "hit2");
`endif
    step(1'b1, 32'h0000_0104, 1'b0, 32'h0, 1'b0, 2'b01, 1'b0, 1'b0, "hit3");
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'b00, 1'b1, 1'b0, "hit_idle");

    // Reset half a cycle after a grant: the pending response must never appear
    step(1'b1, 32'h0000_0040, 1'b0, 32'h0, 1'b0, 2'b01, 1'b0, 1'b0, "pre_rst");
    do_reset("mid_rst");
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'b00, 1'b1, 1'b0, "post_rst0");
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'b00, 1'b1, 1'b0, "post_rst1");
    step(1'b0, 32'h0, 1'b1, 32'h0000_0008, 1'b0, 2'b10, 1'b0, 1'b0, "post_rst2");
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'b00, 1'b1, 1'b0, "post_rst3");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
